// File: rtl/mac_feeder.sv
// Operand sequencer for the mac accumulator: it buffers one A-row and one B-column,
// streams them into the MAC, and returns the dot product on a valid/ready port.
module mac_feeder #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [2:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic [3:0]        len,
    output logic              busy,
    output logic              macc_clear,
    output logic [DATA_W-1:0] inA,
    output logic [DATA_W-1:0] inB,
    input  logic [ACC_W-1:0]  macc_out,
    output logic              res_valid,
    output logic [ACC_W-1:0]  res_data,
    input  logic              res_ready
);

    localparam int unsigned LEN_W = 4;
    localparam int unsigned AW    = $clog2(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        HOLD
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] buf_a [DEPTH];
    logic [DATA_W-1:0] buf_b [DEPTH];
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  k_q;
    logic              drain_q;

    // Operand/clear registers are loaded from the current state, so the MAC sees each
    // phase one cycle after the FSM enters it; drain_q marks the cycle where the last
    // product has landed in macc_out and can be captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            macc_clear <= 1'b1;
            inA        <= '0;
            inB        <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            len_q      <= '0;
            k_q        <= '0;
            drain_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_a[i] <= '0;
                buf_b[i] <= '0;
            end
        end else begin
            macc_clear <= 1'b0;
            inA        <= '0;
            inB        <= '0;
            drain_q    <= 1'b0;

            // Buffers are frozen for the whole job.
            if (wr_en && !busy) begin
                if (wr_sel) buf_b[wr_addr] <= wr_data;
                else        buf_a[wr_addr] <= wr_data;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= CLEAR;
                        busy  <= 1'b1;
                        len_q <= (len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len;
                        k_q   <= '0;
                    end
                end
                CLEAR: begin
                    macc_clear <= 1'b1;
                    state      <= (len_q == '0) ? DRAIN : STREAM;
                end
                STREAM: begin
                    inA <= buf_a[k_q[AW-1:0]];
                    inB <= buf_b[k_q[AW-1:0]];
                    k_q <= k_q + LEN_W'(1);
                    if (k_q == len_q - LEN_W'(1)) state <= DRAIN;
                end
                DRAIN: begin
                    drain_q <= 1'b1;
                    state   <= HOLD;
                end
                HOLD: begin
                    if (drain_q) begin
                        res_data  <= macc_out;
                        res_valid <= 1'b1;
                    end else if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_feeder.sv
// Randomized scoreboard bench for mac_feeder with a behavioural mac attached to its
// operand port; expected dot products come from plain-array arithmetic.
module tb_mac_feeder;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ACC_W  = 19;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic              wr_sel = 1'b0;
    logic [2:0]        wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              start = 1'b0;
    logic [3:0]        len = '0;
    logic              busy;
    logic              macc_clear;
    logic [DATA_W-1:0] inA;
    logic [DATA_W-1:0] inB;
    logic [ACC_W-1:0]  macc_out;
    logic              res_valid;
    logic [ACC_W-1:0]  res_data;
    logic              res_ready = 1'b1;

    mac_feeder #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .len(len), .busy(busy),
        .macc_clear(macc_clear), .inA(inA), .inB(inB), .macc_out(macc_out),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    // Behavioural mac: clear overrides, otherwise accumulate the sign-extended product.
    logic signed [ACC_W-1:0] acc;
    logic signed [15:0]      prod;
    assign prod     = $signed(inA) * $signed(inB);
    assign macc_out = acc;
    always @(posedge clk) begin
        if (macc_clear) acc <= '0;
        else            acc <= acc + ACC_W'(prod);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int val;
        int lat;
        int t0;
    } exp_t;

    exp_t sb[$];
    int   a_m [DEPTH];
    int   b_m [DEPTH];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int dot(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += a_m[i] * b_m[i];
        return s;
    endfunction

    // Monitor: checks each presented result against the head of the scoreboard.
    logic prev_v = 1'b0;
    int   held   = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (res_valid && !prev_v) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("res_data", int'($signed(res_data)), e.val);
                    chk("latency", cyc - e.t0, e.lat);
                end
                held = int'($signed(res_data));
            end else if (res_valid) begin
                chk("res_data_stable", int'($signed(res_data)), held);
            end
            prev_v = res_valid;
        end
    end

    task automatic wr(input logic sel, input int addr, input int val);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = 3'(addr);
        wr_data = DATA_W'(val);
        if (sel) b_m[addr] = val; else a_m[addr] = val;
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    // Launch a job, optionally with a concurrent write, stall res_ready, and poke
    // start/wr_en while the result is held.
    task automatic run_job(input int l, input int stall, input bit poke,
                           input bit cw, input logic cw_sel, input int cw_addr, input int cw_val);
        int   le, clears, nz, first_op, clear_at, stall_left;
        bit   done;
        exp_t e;
        le = (l > DEPTH) ? DEPTH : l;
        clears = 0; nz = 0; first_op = -1; clear_at = -1; stall_left = stall; done = 0;
        @(negedge clk);
        start     = 1'b1;
        len       = 4'(l);
        res_ready = (stall == 0);
        if (cw) begin
            wr_en   = 1'b1;
            wr_sel  = cw_sel;
            wr_addr = 3'(cw_addr);
            wr_data = DATA_W'(cw_val);
            if (cw_sel) b_m[cw_addr] = cw_val; else a_m[cw_addr] = cw_val;
        end
        e.val = dot(le);
        e.lat = le + 3;
        @(posedge clk);
        #1;
        e.t0 = cyc;
        sb.push_back(e);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            start = 1'b0;
            wr_en = 1'b0;
            if (macc_clear) begin clears++; clear_at = c; end
            if (inA != '0 || inB != '0) begin
                nz++;
                if (first_op < 0) first_op = c;
            end
            if (!busy) begin done = 1; break; end
            if (res_valid) begin
                if (stall_left > 0) begin
                    if (poke) begin
                        start   = 1'b1;
                        len     = 4'd3;
                        wr_en   = 1'b1;
                        wr_sel  = 1'b0;
                        wr_addr = 3'd0;
                        wr_data = 8'd55;
                        chk("busy_in_hold", busy, 1);
                    end
                    stall_left--;
                    res_ready = 1'b0;
                end else begin
                    res_ready = 1'b1;
                end
            end
        end
        start = 1'b0;
        wr_en = 1'b0;
        res_ready = 1'b1;
        chk("job_done", done, 1);
        chk("clear_pulses", clears, 1);
        if (le == 0) chk("len0_operands", nz, 0);
        else if (a_m[0] != 0) chk("clear_before_op", first_op, clear_at + 1);
        @(negedge clk);
        chk("idle_after", busy, 0);
    endtask

    task automatic scenario1();
        wr(0, 0, 10); wr(0, 1, 5); wr(0, 2, -4);
        wr(1, 0, 3);  wr(1, 1, 2); wr(1, 2, 1);
        chk("model_36", dot(3), 36);
        run_job(3, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin a_m[i] = 0; b_m[i] = 0; end
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_data", res_data, 0);
        chk("rst_inA", inA, 0);
        chk("rst_inB", inB, 0);
        chk("rst_clear", macc_clear, 1);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1 chk("post_rst_clear", macc_clear, 0);

        // Zeroed buffers give zero.
        run_job(8, 0, 0, 0, 0, 0, 0);
        scenario1();
        // Concurrent write lands before the job reads it; prior 36 must be cleared.
        wr(0, 0, 7);
        run_job(1, 0, 0, 1, 1, 0, -6);

        for (int i = 0; i < DEPTH; i++) begin wr(0, i, -128); wr(1, i, -128); end
        run_job(8, 0, 0, 0, 0, 0, 0);
        run_job(15, 0, 0, 0, 0, 0, 0);
        run_job(8, 5, 1, 0, 0, 0, 0);
        // A[0] must still be -128 after the ignored write.
        run_job(1, 0, 0, 0, 0, 0, 0);
        run_job(0, 0, 0, 0, 0, 0, 0);

        // Reset in the 2nd stream cycle of a len=5 job.
        @(negedge clk);
        start = 1'b1;
        len   = 4'd5;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", res_valid, 0);
        chk("midrst_clear", macc_clear, 1);
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin a_m[i] = 0; b_m[i] = 0; end
        @(posedge clk);
        #1;
        chk("midrst_clear_low", macc_clear, 0);
        chk("midrst_idle", busy, 0);
        repeat (15) @(posedge clk);
        scenario1();

        for (int j = 0; j < 25; j++) begin
            int nw;
            nw = $urandom_range(0, 6);
            for (int w = 0; w < nw; w++)
                wr(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1),
                   int'($signed(8'($urandom))));
            run_job($urandom_range(0, 15), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, DEPTH - 1), int'($signed(8'($urandom))));
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_feeder.md
# mac_feeder

Operand sequencer that drives the `mac` accumulator in the GEMM datapath. It holds one A-row and one B-column, up to 8 signed 8-bit elements each, in local buffers. On `start` it clears the MAC, streams `len` element pairs into `inA`/`inB` one per cycle, captures `macc_out`, and presents the dot product on a valid/ready result port. It is the producer end of the `mac` operand interface and the consumer of its result.

## Interface
Parameters:
- `DEPTH`, 8: maximum vector length (buffer entries per operand).
- `DATA_W`, 8: operand width, signed two's complement.
- `ACC_W`, 19: accumulator/result width; matches `mac.macc_out`.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `wr_en`  in  1: buffer write strobe.
- `wr_sel`  in  1: 0 selects buffer A, 1 selects buffer B.
- `wr_addr`  in  3: element index, 0..DEPTH-1.
- `wr_data`  in  DATA_W: signed element value.
- `start`  in  1: begin a dot product; sampled only in IDLE.
- `len`  in  4: element count, sampled with `start`.
- `busy`  out  1: high whenever state is not IDLE.
- `macc_clear`  out  1: to `mac.macc_clear`.
- `inA`, `inB`  out  DATA_W each: to `mac.inA` / `mac.inB`.
- `macc_out`  in  ACC_W: from `mac.macc_out`.
- `res_valid`  out  1: result available.
- `res_data`  out  ACC_W: signed dot product.
- `res_ready`  in  1: consumer accepts the result.

## Operation
- MAC contract, fixed:
  - On each edge, if `macc_clear` is high, acc <= 0, and `macc_clear` overrides the operands.
  - Otherwise acc <= acc + inA*inB.
  - `macc_out` is the registered acc.
- Reset values: state IDLE; `macc_clear`=1 while `rst` is high, so the MAC is cleared because it has no reset of its own. All other outputs (`busy`, `inA`, `inB`, `res_valid`, `res_data`) are 0. Both buffers are zeroed.
- Writes:
  - Accepted only when `busy`=0.
  - Ignored while busy, so the buffers stay frozen during a job.
  - A write and a `start` in the same IDLE cycle: the write lands, and the job uses the new value.
- Length rules:
  - `len` > DEPTH is clamped to DEPTH.
  - `len`=0 skips STREAM and yields 0.
- FSM:
  - IDLE: `macc_clear`=0, `inA`=`inB`=0, so the accumulator holds. `start` moves to CLEAR and latches the effective length and k=0.
  - CLEAR (1 cycle): `macc_clear`=1, operands 0. Moves to STREAM, or to DRAIN if len=0.
  - STREAM (len cycles): `macc_clear`=0, `inA`=A[k], `inB`=B[k], k increments. After the k=len-1 cycle, moves to DRAIN.
  - DRAIN (1 cycle): operands 0, so acc holds. Captures `macc_out` into `res_data`, sets `res_valid`, then moves to HOLD.
  - HOLD: `res_valid`=1, with `res_data` stable. When `res_valid` and `res_ready` are both high at an edge, clears `res_valid` and returns to IDLE.
- `start` is ignored in every state except IDLE.
- Arithmetic:
  - Products are 16-bit signed, sign-extended to ACC_W.
  - The worst case is 8 × (−128)(−128) = 131072, which fits in 19 bits signed, so no overflow handling is required.
- `rst` asserted in any state, including mid-STREAM or in HOLD with unaccepted data: the result is discarded, all outputs take reset values on the next edge, and the FSM returns to IDLE.

## Timing
- `start` sampled high at edge t (IDLE):
  - CLEAR occupies cycle t..t+1.
  - STREAM occupies len cycles.
  - DRAIN occupies 1 cycle.
  - `res_valid` rises after edge t+len+3.
- Start-to-valid latency is len+3 cycles, so 3 for len=0 and 11 for len=8.
- A back-to-back job: the earliest next `start` is sampled the cycle after the handshake, once back in IDLE.
- Operands and `macc_clear` are registered outputs: each changes only on an edge and is stable for the whole cycle.

## Test plan
- Write A=[10,5,−4], B=[3,2,1]; pulse `start` with len=3 and `res_ready`=1 → `res_valid` high 6 cycles after the start edge with `res_data`=36, and `macc_clear` high for exactly 1 cycle before the first operand.
- Follow with A[0]=7, B[0]=−6; start len=1 → `res_data`=−42, proving the clear removed the prior 36.
- All 8 entries of A and B = −128; len=8 → `res_data`=131072, valid after 11 cycles; then len=15 with the same buffers → also 131072 (clamp to DEPTH).
- Hold `res_ready` low for 5 cycles after valid, and pulse `start` and `wr_en` meanwhile → `res_valid`/`res_data` stable, start ignored, buffer unchanged, `busy`=1; result accepted when `res_ready`=1, then `busy`=0.
- len=0 → `res_data`=0, valid 3 cycles after start, and `inA`/`inB` never nonzero.
- Assert `rst` for 1 cycle during the 2nd STREAM cycle of a len=5 job → next edge gives `busy`=0, `res_valid`=0, `macc_clear`=1 during reset then 0, and no result emitted; rerunning the first scenario yields 36.
